// File: rtl/fpga_cfg_pkg.sv
// Shared types and default sizing for the fabric configuration loader.
package fpga_cfg_pkg;

  // Loader sequencing: connection chain first, one idle cycle, then the CLB chain.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CONN = 3'd1,
    GAP  = 3'd2,
    CLB  = 3'd3,
    DONE = 3'd4
  } state_t;

  localparam int DEF_CONN_CHAIN_LEN = 256;
  localparam int DEF_CLB_CHAIN_LEN  = 72;
  localparam int WORD_WIDTH         = 8;

endpackage

// File: rtl/scan_serializer.sv
// Word buffer, bit serializer and readback assembler shared by both scan phases.
// The buffer count doubles as the "shifting this cycle" flag: a non-zero count
// means the registered scan outputs currently carry a valid bit.
module scan_serializer #(
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cfg_ready,
  input  logic                  i_cfg_valid,
  input  logic [WORD_WIDTH-1:0] i_cfg_data,
  input  logic                  i_phase_last,
  input  logic                  i_scan_out,
  output logic                  o_shift,
  output logic                  o_next_bit,
  output logic                  o_next_nonempty,
  output logic                  o_next_le1,
  output logic [WORD_WIDTH-1:0] o_rd_data,
  output logic                  o_rd_valid
);
  import fpga_cfg_pkg::*;

  localparam int CW = $clog2(WORD_WIDTH + 1);
  localparam int IW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;

  logic [WORD_WIDTH-1:0] r_buf;
  logic [WORD_WIDTH-1:0] w_buf_next;
  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         w_cnt_next;
  logic [WORD_WIDTH-1:0] r_acc;
  logic [WORD_WIDTH-1:0] w_acc_bit;
  logic [IW-1:0]         r_idx;
  logic [WORD_WIDTH-1:0] r_rd_data;
  logic                  r_rd_valid;
  logic                  w_accept;
  logic                  w_word_end;

  assign o_shift         = (r_cnt != '0);
  assign w_accept        = i_cfg_valid & i_cfg_ready;
  assign o_next_bit      = w_buf_next[0];
  assign o_next_nonempty = (w_cnt_next != '0);
  assign o_next_le1      = (w_cnt_next <= CW'(1));
  assign o_rd_data       = r_rd_data;
  assign o_rd_valid      = r_rd_valid;

  // Buffer next state: phase end drops surplus bits, a new word replaces the one finishing, else shift.
  always_comb begin
    w_buf_next = r_buf;
    w_cnt_next = r_cnt;
    if (o_shift && i_phase_last) begin
      w_buf_next = '0;
      w_cnt_next = '0;
    end else if (w_accept) begin
      w_buf_next = i_cfg_data;
      w_cnt_next = CW'(WORD_WIDTH);
    end else if (o_shift) begin
      w_buf_next = r_buf >> 1;
      w_cnt_next = r_cnt - CW'(1);
    end
  end

  // Word buffer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else begin
      r_buf <= w_buf_next;
      r_cnt <= w_cnt_next;
    end
  end

  // Insert the sampled chain tail into the word being assembled.
  always_comb begin
    w_acc_bit        = r_acc;
    w_acc_bit[r_idx] = i_scan_out;
  end

  assign w_word_end = (r_idx == IW'(WORD_WIDTH - 1)) || i_phase_last;

  // Readback assembly: publish a word when full or at the phase's last bit (upper bits stay zero).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc      <= '0;
      r_idx      <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      if (o_shift) begin
        if (w_word_end) begin
          r_rd_data  <= w_acc_bit;
          r_rd_valid <= 1'b1;
          r_acc      <= '0;
          r_idx      <= '0;
        end else begin
          r_acc <= w_acc_bit;
          r_idx <= r_idx + IW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/fpga_config_loader.sv
// Configuration loader for the 2x2 fabric: streams words into the connection
// chain, then the CLB chain, reading back the previous chain contents.
module fpga_config_loader #(
  parameter int CONN_CHAIN_LEN = fpga_cfg_pkg::DEF_CONN_CHAIN_LEN,
  parameter int CLB_CHAIN_LEN  = fpga_cfg_pkg::DEF_CLB_CHAIN_LEN,
  parameter int WORD_WIDTH     = fpga_cfg_pkg::WORD_WIDTH
) (
  input  logic                  scan_clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [WORD_WIDTH-1:0] cfg_data,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  output logic                  conn_scan_in,
  output logic                  conn_scan_en,
  input  logic                  conn_scan_out,
  output logic                  clb_scan_in,
  output logic                  clb_scan_en,
  input  logic                  clb_scan_out,
  output logic [WORD_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  busy,
  output logic                  done
);
  import fpga_cfg_pkg::*;

  localparam int CCW = $clog2(CONN_CHAIN_LEN + 1);
  localparam int LCW = $clog2(CLB_CHAIN_LEN + 1);

  state_t         r_state;
  state_t         w_state_next;
  logic [CCW-1:0] r_conn_cnt;
  logic [CCW-1:0] w_conn_cnt_next;
  logic [LCW-1:0] r_clb_cnt;
  logic [LCW-1:0] w_clb_cnt_next;

  logic w_shift;
  logic w_phase_last;
  logic w_scan_out;
  logic w_next_bit;
  logic w_next_nonempty;
  logic w_next_le1;
  logic w_ready_next;

  logic r_cfg_ready;
  logic r_conn_scan_in;
  logic r_conn_scan_en;
  logic r_clb_scan_in;
  logic r_clb_scan_en;
  logic r_busy;
  logic r_done;

  assign cfg_ready    = r_cfg_ready;
  assign conn_scan_in = r_conn_scan_in;
  assign conn_scan_en = r_conn_scan_en;
  assign clb_scan_in  = r_clb_scan_in;
  assign clb_scan_en  = r_clb_scan_en;
  assign busy         = r_busy;
  assign done         = r_done;

  scan_serializer #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_ser (
    .clk            (scan_clk),
    .rst            (rst),
    .i_cfg_ready    (r_cfg_ready),
    .i_cfg_valid    (cfg_valid),
    .i_cfg_data     (cfg_data),
    .i_phase_last   (w_phase_last),
    .i_scan_out     (w_scan_out),
    .o_shift        (w_shift),
    .o_next_bit     (w_next_bit),
    .o_next_nonempty(w_next_nonempty),
    .o_next_le1     (w_next_le1),
    .o_rd_data      (rd_data),
    .o_rd_valid     (rd_valid)
  );

  // Select the active chain's tail and flag the phase's final bit.
  always_comb begin
    w_phase_last = 1'b0;
    w_scan_out   = 1'b0;
    case (r_state)
      CONN: begin
        w_phase_last = (r_conn_cnt == CCW'(1));
        w_scan_out   = conn_scan_out;
      end
      CLB: begin
        w_phase_last = (r_clb_cnt == LCW'(1));
        w_scan_out   = clb_scan_out;
      end
      default: ;
    endcase
  end

  // Next state and per-chain down-counters (bits still to shift, never wrapping).
  always_comb begin
    w_state_next    = r_state;
    w_conn_cnt_next = r_conn_cnt;
    w_clb_cnt_next  = r_clb_cnt;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next    = CONN;
          w_conn_cnt_next = CCW'(CONN_CHAIN_LEN);
          w_clb_cnt_next  = LCW'(CLB_CHAIN_LEN);
        end
      end
      CONN: begin
        if (w_shift && (r_conn_cnt != '0)) begin
          w_conn_cnt_next = r_conn_cnt - CCW'(1);
          if (w_phase_last) w_state_next = GAP;
        end
      end
      GAP: w_state_next = CLB;
      CLB: begin
        if (w_shift && (r_clb_cnt != '0)) begin
          w_clb_cnt_next = r_clb_cnt - LCW'(1);
          if (w_phase_last) w_state_next = DONE;
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Ready for next cycle: buffer empty or on its last bit, and the phase needs more than the buffer holds.
  always_comb begin
    w_ready_next = 1'b0;
    case (w_state_next)
      CONN: w_ready_next = w_next_le1 &&
                           (w_conn_cnt_next > (w_next_nonempty ? CCW'(1) : CCW'(0)));
      CLB:  w_ready_next = w_next_le1 &&
                           (w_clb_cnt_next > (w_next_nonempty ? LCW'(1) : LCW'(0)));
      default: ;
    endcase
  end

  // State, counters and status outputs.
  always_ff @(posedge scan_clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_conn_cnt  <= '0;
      r_clb_cnt   <= '0;
      r_cfg_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_conn_cnt  <= w_conn_cnt_next;
      r_clb_cnt   <= w_clb_cnt_next;
      r_cfg_ready <= w_ready_next;
      r_busy      <= (w_state_next != IDLE);
      r_done      <= (w_state_next == DONE);
    end
  end

  // Scan pins: enable only the active chain, hold data when starved, park the idle chain at 0.
  always_ff @(posedge scan_clk or posedge rst) begin
    if (rst) begin
      r_conn_scan_in <= 1'b0;
      r_conn_scan_en <= 1'b0;
      r_clb_scan_in  <= 1'b0;
      r_clb_scan_en  <= 1'b0;
    end else begin
      r_conn_scan_en <= (w_state_next == CONN) && w_next_nonempty;
      r_clb_scan_en  <= (w_state_next == CLB) && w_next_nonempty;
      if (w_state_next != CONN)  r_conn_scan_in <= 1'b0;
      else if (w_next_nonempty)  r_conn_scan_in <= w_next_bit;
      if (w_state_next != CLB)   r_clb_scan_in  <= 1'b0;
      else if (w_next_nonempty)  r_clb_scan_in  <= w_next_bit;
    end
  end

endmodule
